wcu_multi: RTL and testbench

//  Next-generation worker control unit for the Julia worker. Sequences one job of

---
 rtl/wcu_multi.sv | 103 ++++++++++
 tb/tb_wcu_multi.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/wcu_multi.sv
// wcu_multi: worker control unit sequencing calc lanes, convert and MC write per batch of a job.
// Optional watchdog on the wait states is enabled by defining WCU_TIMEOUT_EN.
module wcu_multi #(
  parameter int NUM_LANES      = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 JW_start,
  input  logic [CNT_W-1:0]     batch_count,
  input  logic [NUM_LANES-1:0] lane_mask,
  output logic                 JW_ready,
  output logic                 JW_done,
  output logic [NUM_LANES-1:0] calc_start,
  input  logic [NUM_LANES-1:0] calc_done,
  output logic                 convert_start,
  input  logic                 convert_done,
  input  logic                 MC_busy,
  output logic                 MC_req,
  output logic [CNT_W-1:0]     batch_idx,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, CALC_GO, CALC_WAIT, CONV_GO, CONV_WAIT, MC_WAIT, DONE} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, idx_q, idx_d;
  logic [NUM_LANES-1:0] mask_q, mask_d, sticky_q, sticky_d;
  logic                 accept, lanes_ok, last;
  assign accept   = JW_start && batch_count != '0 && lane_mask != '0;
  assign lanes_ok = (sticky_q | (calc_done & mask_q)) == mask_q;
  assign last     = idx_q == cnt_q - CNT_W'(1);
`ifdef WCU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d, timeout;
  assign timeout = (state_q == CALC_WAIT || state_q == CONV_WAIT || state_q == MC_WAIT) &&
                   wd_q == WD_W'(TIMEOUT_CYCLES - 1);
  assign err = err_q;
`else
  // no watchdog: constant 0 for every legal TIMEOUT_CYCLES
  assign err = TIMEOUT_CYCLES < 1;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    sticky_d = state_q == CALC_GO ? '0 :
               state_q == CALC_WAIT ? sticky_q | (calc_done & mask_q) : sticky_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = CALC_GO;
        cnt_d   = batch_count;
        mask_d  = lane_mask;
        idx_d   = '0;
      end
      CALC_GO:   state_d = CALC_WAIT;
      CALC_WAIT: state_d = lanes_ok ? CONV_GO : CALC_WAIT;
      CONV_GO:   state_d = CONV_WAIT;
      CONV_WAIT: state_d = convert_done ? MC_WAIT : CONV_WAIT;
      MC_WAIT: if (!MC_busy) begin
        state_d = last ? DONE : CALC_GO;
        idx_d   = last ? idx_q : idx_q + CNT_W'(1);
      end
      default:   state_d = IDLE;
    endcase
`ifdef WCU_TIMEOUT_EN
    // a handshake completing on the limit cycle still wins over the watchdog
    if (timeout && state_d == state_q) state_d = DONE;
    wd_d  = state_d != state_q ? '0 : wd_q + WD_W'(1);
    err_d = (state_q == IDLE && accept) ? 1'b0 : (timeout && state_d == DONE) ? 1'b1 : err_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      sticky_q <= '0;
`ifdef WCU_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      sticky_q <= sticky_d;
`ifdef WCU_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end
  assign JW_ready      = state_q == IDLE;
  assign JW_done       = state_q == DONE;
  assign calc_start    = state_q == CALC_GO ? mask_q : '0;
  assign convert_start = state_q == CONV_GO;
  assign MC_req        = state_q == MC_WAIT;
  assign batch_idx     = idx_q;
endmodule

// File: tb/tb_wcu_multi.sv
// tb_wcu_multi: randomized responder bench; expected outputs follow from the per-batch handshake delays it picks.
module tb_wcu_multi;
  logic       clk = 0, rst = 1, JW_start = 0, convert_done = 0, MC_busy = 0;
  logic [7:0] batch_count = 0;
  logic [3:0] lane_mask = 0, calc_done = 0;
  logic       JW_ready, JW_done, convert_start, MC_req, err;
  logic [3:0] calc_start;
  logic [7:0] batch_idx;
  int checks = 0, errors = 0;
  int fd[4] = '{-1, -1, -1, -1};
  int fe = -1, fb = -1;

  always #5 clk = ~clk;

  wcu_multi #(.NUM_LANES(4), .CNT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .JW_start(JW_start), .batch_count(batch_count), .lane_mask(lane_mask),
    .JW_ready(JW_ready), .JW_done(JW_done), .calc_start(calc_start), .calc_done(calc_done),
    .convert_start(convert_start), .convert_done(convert_done), .MC_busy(MC_busy),
    .MC_req(MC_req), .batch_idx(batch_idx), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job: each batch draws lane/convert/MC delays, and the bench predicts every cycle from them.
  task automatic run_job(input int cnt, input logic [3:0] m, input int rst_k);
    int d[4];
    bit lvl[4];
    int dmax, e, b;
    @(negedge clk);
    chk("idle_ready", JW_ready, 1);
    JW_start = 1; batch_count = 8'(cnt); lane_mask = m;
    for (int k = 0; k < cnt; k++) begin
      dmax = 1;
      for (int i = 0; i < 4; i++) begin
        d[i]   = fd[i] >= 0 ? fd[i] : int'($urandom_range(1, 5));
        lvl[i] = 1'($urandom_range(0, 1));
        if (m[i] && d[i] > dmax) dmax = d[i];
      end
      e = fe >= 0 ? fe : int'($urandom_range(1, 3));
      b = fb >= 0 ? fb : int'($urandom_range(0, 3));
      @(negedge clk);
      chk("calc_start_go", calc_start, m);
      chk("batch_idx_go", batch_idx, k);
      chk("ready_in_job", JW_ready, 0);
      chk("err_in_job", err, 0);
      JW_start = 1'($urandom_range(0, 1)); batch_count = 8'($urandom); lane_mask = 4'($urandom);
      calc_done = 4'($urandom); MC_busy = 1'($urandom_range(0, 1));
      for (int t = 1; t <= dmax; t++) begin
        @(negedge clk);
        chk("calc_wait_quiet", {calc_start, convert_start, MC_req}, 0);
        for (int i = 0; i < 4; i++)
          calc_done[i] = m[i] ? (t == d[i] || (lvl[i] && t > d[i])) : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("convert_start", convert_start, 1);
      chk("calc_start_off", calc_start, 0);
      calc_done = 0;
      for (int t = 1; t <= e; t++) begin
        @(negedge clk);
        chk("conv_wait_quiet", {convert_start, MC_req}, 0);
        if (k == rst_k) begin
          rst = 1; JW_start = 0;
          @(negedge clk);
          rst = 0;
          chk("rst_ready", JW_ready, 1);
          chk("rst_idx", batch_idx, 0);
          chk("rst_no_done", JW_done, 0);
          chk("rst_quiet", {calc_start, convert_start, MC_req}, 0);
          @(negedge clk);
          chk("rst_still_idle", {JW_ready, JW_done}, 2'b10);
          return;
        end
        convert_done = (t == e);
      end
      for (int t = 0; t <= b; t++) begin
        @(negedge clk);
        convert_done = 0;
        chk("mc_req", MC_req, 1);
        chk("mc_idx", batch_idx, k);
        MC_busy = (t < b);
      end
    end
    @(negedge clk);
    chk("jw_done", JW_done, 1);
    chk("done_not_ready", JW_ready, 0);
    JW_start = 0; MC_busy = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_pulse", JW_done, 0);
    chk("ready_back", JW_ready, 1);
    chk("err_after_job", err, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", JW_ready, 1);
    chk("reset_idx", batch_idx, 0);
    chk("reset_outs", {JW_done, calc_start, convert_start, MC_req, err}, 0);
    rst = 0;
    // single fast batch, everything answered at once
    fd = '{1, 1, 1, 1}; fe = 1; fb = 0;
    run_job(1, 4'hF, -1);
    // sparse mask with staggered lanes
    fd = '{2, -1, 7, -1}; fe = -1; fb = -1;
    run_job(3, 4'b0101, -1);
    // MC busy for 10 cycles
    fd = '{-1, -1, -1, -1}; fb = 10;
    run_job(2, 4'b1011, -1);
    fb = -1;
    // illegal requests in IDLE are ignored
    @(negedge clk);
    JW_start = 1; batch_count = 0; lane_mask = 4'hF;
    @(negedge clk);
    chk("zero_count_ignored", {JW_ready, calc_start}, 5'b10000);
    batch_count = 3; lane_mask = 0;
    @(negedge clk);
    chk("zero_mask_ignored", {JW_ready, calc_start}, 5'b10000);
    JW_start = 0;
    // reset during the second batch's convert wait
    run_job(2, 4'hF, 1);
    for (int j = 0; j < 6; j++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_job(int'($urandom_range(1, 4)), m, -1);
    end
`ifdef WCU_TIMEOUT_EN
    @(negedge clk);
    JW_start = 1; batch_count = 1; lane_mask = 4'hF;
    @(negedge clk);
    JW_start = 0; calc_done = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      chk("wd_waiting", JW_done, 0);
    end
    @(negedge clk);
    chk("wd_done", JW_done, 1);
    chk("wd_err", err, 1);
    @(negedge clk);
    chk("wd_err_held", {JW_ready, err}, 2'b11);
    run_job(1, 4'h3, -1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
